// File: rtl/riscV_unrn_pkg.sv
// Shared definitions for the UART receive slave: bus types, register bit
// positions, address map entry and FSM state encoding.
package riscV_unrn_pkg;

  localparam logic [31:0] UART_RX_BASE      = 32'h104;
  localparam int unsigned UART_RX_SLAVE_IDX = 3;
  localparam int unsigned UART_RX_SIZE      = 4;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned RXD_VALID_BIT   = 8;
  localparam int unsigned RXD_OVERRUN_BIT = 9;
  localparam int unsigned RXD_FERR_BIT    = 10;

  typedef struct packed {
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] write_data;
    logic [3:0]  mask_byte;
  } mem_cmd_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic        ready;
  } mem_result_t;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  // Rounded clock cycles per oversample tick.
  function automatic int unsigned calc_div(int unsigned clk_hz, int unsigned baud);
    return (clk_hz + baud * (UART_OVERSAMPLE / 2)) / (baud * UART_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: power-of-two ring with a separate occupancy count.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_eff, pop_eff;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_eff  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push_eff = push & (~full | pop_eff);
  assign data     = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_eff && !pop_eff)      count_q <= count_q + 1'b1;
      else if (pop_eff && !push_eff) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_slave.sv
// 8N1 UART receiver with 16x oversampling, a small receive FIFO and a
// single-word bus register (data, valid, overrun, frame error).
module uart_rx_slave
  import riscV_unrn_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        we_in,
  input  mem_cmd_t    cmd_in,
  output mem_result_t result_out,
  output logic        irq_o
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            overrun_q, ferr_q;

  logic       start_edge, tick, push, ferr_set, rd_pop, flag_clr, flush;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_data;
  logic [31:0] rd_word;
  logic       unused_cmd;

  assign unused_cmd = ^{cmd_in.addr, cmd_in.mem_write, cmd_in.write_data[31:2],
                        cmd_in.mask_byte[3:1]};

  assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_sync2_q;
  assign tick       = (state_q != StIdle) && (div_q == DivW'(DIV - 1));
  assign rd_pop     = cmd_in.mem_read && !fifo_empty;
  assign flag_clr   = we_in && cmd_in.mask_byte[0] && cmd_in.write_data[0];
  assign flush      = we_in && cmd_in.write_data[1];

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    ferr_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d    = StStart;
          tick_cnt_d = '0;
        end
      end
      StStart: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_sync2_q ? StIdle : StData;
          end
        end
      end
      StData: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == 4'(UART_OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            shift_d    = {rx_sync2_q, shift_q[7:1]};
            bit_idx_d  = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == 4'(UART_OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            push       = rx_sync2_q;
            ferr_set   = !rx_sync2_q;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Tick divider only runs while a frame is in progress.
    if (state_d == StIdle || start_edge || tick) div_d = '0;
    else                                         div_d = div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      div_q      <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_sync1_q <= rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      // Setting takes priority over a software clear in the same cycle.
      if (push && fifo_full && !rd_pop) overrun_q <= 1'b1;
      else if (flag_clr)                overrun_q <= 1'b0;
      if (ferr_set)      ferr_q <= 1'b1;
      else if (flag_clr) ferr_q <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (rd_pop),
    .flush   (flush),
    .wr_data (shift_q),
    .data    (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    rd_word = '0;
    if (!fifo_empty) rd_word[7:0] = fifo_data;
    rd_word[RXD_VALID_BIT]   = !fifo_empty;
    rd_word[RXD_OVERRUN_BIT] = overrun_q;
    rd_word[RXD_FERR_BIT]    = ferr_q;
    if (!rst) rd_word = '0;
    result_out           = '0;
    result_out.read_data = rd_word;
  end

  assign irq_o = rst && (!fifo_empty || overrun_q || ferr_q);

endmodule

// File: tb/tb_uart_rx_slave.sv
// Directed plus randomized frames against a queue-based model of the
// receive register.
module tb_uart_rx_slave;
  import riscV_unrn_pkg::*;

  localparam int unsigned CLK_HZ = 7_372_800;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BIT    = 64;

  logic        clk = 1'b0;
  logic        rst, rx, we_in;
  mem_cmd_t    cmd_in;
  mem_result_t result_out;
  logic        irq_o;

  int checks = 0;
  int passed = 0;

  logic [7:0] mq[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  uart_rx_slave #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .we_in      (we_in),
    .cmd_in     (cmd_in),
    .result_out (result_out),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word();
    logic [31:0] w = '0;
    if (mq.size() > 0) begin
      w[7:0] = mq[0];
      w[8]   = 1'b1;
    end
    w[9]  = m_ovr;
    w[10] = m_ferr;
    return w;
  endfunction

  function automatic logic exp_irq();
    return (mq.size() > 0) || m_ovr || m_ferr;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic m_frame(input logic [7:0] b, input logic stop);
    if (!stop)                  m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else                        mq.push_back(b);
  endtask

  task automatic m_pop();
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  // Sends the first nbits of a 10-bit 8N1 frame, then idles briefly.
  task automatic send(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = frame[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_ok(input logic [7:0] b, input logic stop);
    send(b, stop, 10);
    m_frame(b, stop);
  endtask

  task automatic do_read(input string tag);
    @(negedge clk);
    cmd_in.mem_read = 1'b1;
    #1;
    check(tag, result_out.read_data, exp_word());
    m_pop();
    @(negedge clk);
    cmd_in.mem_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] wd, input logic [3:0] mask);
    @(negedge clk);
    we_in = 1'b1;
    cmd_in.write_data = wd;
    cmd_in.mask_byte = mask;
    @(negedge clk);
    we_in = 1'b0;
    cmd_in.write_data = '0;
    cmd_in.mask_byte = '0;
    if (mask[0] && wd[0]) begin
      m_ovr = 1'b0;
      m_ferr = 1'b0;
    end
    if (wd[1]) mq.delete();
  endtask

  task automatic peek(input string tag);
    #1;
    check(tag, result_out.read_data, exp_word());
    check({tag, "_irq"}, {31'b0, irq_o}, {31'b0, exp_irq()});
  endtask

  initial begin
    rst = 1'b0;
    rx = 1'b1;
    we_in = 1'b0;
    cmd_in = '0;
    #1;
    check("reset_data", result_out.read_data, 32'h0);
    check("reset_irq", {31'b0, irq_o}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    peek("after_reset");

    send_ok(8'h55, 1'b1);
    check("rx_55", result_out.read_data, 32'h155);
    peek("rx_55_model");
    do_read("pop_55");
    do_read("empty_after_55");
    check("empty_const", result_out.read_data, 32'h0);

    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_data", result_out.read_data, 32'h0);
    check("glitch_irq", {31'b0, irq_o}, 32'h0);

    send_ok(8'hA3, 1'b0);
    check("ferr_word", result_out.read_data, 32'h400);
    do_write(32'h1, 4'h1);
    check("ferr_cleared", result_out.read_data, 32'h0);

    for (int i = 1; i <= 5; i++) send_ok(8'(i), 1'b1);
    check("overrun_head", result_out.read_data, 32'h301);
    for (int i = 1; i <= 5; i++) do_read($sformatf("ovr_pop%0d", i));
    check("ovr_left", result_out.read_data, 32'h200);
    do_write(32'h1, 4'h1);
    peek("ovr_cleared");

    // Pop lands on the same edge as the stop-bit sample of 0x06.
    for (int i = 1; i <= 4; i++) send_ok(8'(i), 1'b1);
    fork
      send(8'h06, 1'b1, 10);
      begin
        @(negedge clk);
        repeat (610) @(negedge clk);
        cmd_in.mem_read = 1'b1;
        #1;
        check("full_pop_head", result_out.read_data, 32'h101);
        @(negedge clk);
        cmd_in.mem_read = 1'b0;
      end
    join
    m_pop();
    m_frame(8'h06, 1'b1);
    check("no_overrun", result_out.read_data, 32'h102);
    for (int i = 0; i < 4; i++) do_read($sformatf("full_seq%0d", i));
    peek("full_seq_done");

    // Clear coinciding with a frame-error set keeps the flag.
    fork
      send(8'h5A, 1'b0, 10);
      begin
        @(negedge clk);
        repeat (610) @(negedge clk);
        we_in = 1'b1;
        cmd_in.write_data = 32'h1;
        cmd_in.mask_byte = 4'h1;
        @(negedge clk);
        we_in = 1'b0;
        cmd_in.write_data = '0;
        cmd_in.mask_byte = '0;
      end
    join
    m_ferr = 1'b1;
    check("set_wins", result_out.read_data, 32'h400);
    do_write(32'h1, 4'h1);

    send_ok(8'h11, 1'b1);
    send(8'h7E, 1'b1, 5);
    rst = 1'b0;
    #1;
    check("midreset_data", result_out.read_data, 32'h0);
    check("midreset_irq", {31'b0, irq_o}, 32'h0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    peek("post_reset");
    send_ok(8'h81, 1'b1);
    check("rx_81", result_out.read_data, 32'h181);
    do_read("pop_81");
    peek("after_81");

    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      logic       stop;
      int         op;
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_ok(b, stop);
      peek($sformatf("rand_rx%0d", n));
      op = $urandom_range(0, 5);
      if (op <= 1)      do_read($sformatf("rand_rd%0d", n));
      else if (op == 2) do_write(32'h1, 4'($urandom_range(0, 1)));
      else if (op == 3) do_write(32'h2, 4'h0);
      peek($sformatf("rand_op%0d", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_slave.md
UART_RX_SLAVE -- requirements
Module: uart_rx_slave

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial line rate.
REQ-003 Parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, at least 2.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 we_in  input  1  bus write strobe from SlaveBusMux.
REQ-008 cmd_in  input  MemoryBus::Cmd  bus command; uses mem_read, write_data, mask_byte.
REQ-009 result_out  output  MemoryBus::Result  read_data is the RXDATA word; all other fields are 0.
REQ-010 irq_o  output  1  high while the FIFO is non-empty or any error flag is set.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; a 3rd flop SHALL provide the previous value for edge detection.
REQ-012 The tick generator SHALL pulse once every DIV = round(CLK_HZ/(BAUD*16)) cycles (27 at the defaults); its counter SHALL run only outside IDLE and SHALL restart on start-edge detection.
REQ-013 The FSM SHALL have exactly 4 states: IDLE, START, DATA, STOP.
REQ-014 IDLE->START on a synchronized 1->0 edge of rx.
REQ-015 START: at tick 8 the line SHALL be resampled; if 0, go to DATA with bit index 0 and tick count 0; if 1 (false start), return to IDLE with no side effects.
REQ-016 DATA: sample every 16th tick; shift LSB first into an 8-bit register; after bit 7, go to STOP.
REQ-017 STOP: sample at the 16th tick; if 1, push the byte; if 0, discard the byte and set frame_err; return to IDLE in both cases.
REQ-018 Read format: read_data[7:0] = FIFO head (0 when empty); [8] = valid (FIFO non-empty); [9] = overrun; [10] = frame_err; [31:11] = 0.
REQ-019 read_data SHALL be combinational from the current state, so that a single-cycle core can complete a load in the same cycle.
REQ-020 A cycle with cmd_in.mem_read=1 and valid=1 SHALL pop the FIFO on the rising edge that ends the cycle.
REQ-021 A read of an empty FIFO SHALL have no effect.
REQ-022 A write with we_in=1, cmd_in.mask_byte[0]=1 and write_data[0]=1 SHALL clear overrun and frame_err; a write with write_data[1]=1 SHALL flush the FIFO.
REQ-023 A push into a full FIFO SHALL drop the new byte, set overrun, and leave the contents unchanged.
REQ-024 Push and pop in the same cycle: both SHALL take effect, including when the FIFO is full; overrun SHALL NOT be set in that case.
REQ-025 Error flag set and clear in the same cycle: set wins.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; a separate count of log2(FIFO_DEPTH)+1 bits SHALL distinguish full from empty.

Reset
REQ-027 Reset asserted SHALL immediately force: FSM to IDLE, FIFO empty, flags 0, shift register 0, tick counter 0, synchronizer flops to 1.
REQ-028 During reset, result_out.read_data SHALL be 0 and irq_o SHALL be 0.
REQ-029 A frame in progress when reset is asserted SHALL be discarded.
REQ-030 After reset deasserts, reception SHALL resume only on a fresh falling edge of rx.

Structure
REQ-031 riscV_unrn_pkg SHALL hold UART_RX_BASE = 'h104, UART_OVERSAMPLE = 16, and bit positions RXD_VALID_BIT = 8, RXD_OVERRUN_BIT = 9, RXD_FERR_BIT = 10.
REQ-032 The FIFO SHALL be the sub-module uart_rx_fifo (push, pop, flush, data, full, empty), parameterized by DEPTH and WIDTH = 8.
REQ-033 The top level SHALL map the block as SlaveBusMux slave 3 at UART_RX_BASE, size 4.

Verification
REQ-034 Line sends 0x55 (8N1, 115200) -> within 1 bit time after the stop bit, read_data = 0x155; the next read returns 0x000.
REQ-035 A 3-tick low glitch on rx -> FSM returns to IDLE; read_data stays 0; irq_o stays 0.
REQ-036 Send 0xA3 with stop bit forced to 0 -> read_data = 0x400; a write of 1 -> read_data = 0x000.
REQ-037 Send 0x01..0x05 without reading -> read_data = 0x301; pops return 0x301, 0x302, 0x303, 0x304, then 0x200 (0x05 dropped).
REQ-038 FIFO full, pop issued in the stop-bit sample cycle of 0x06 -> no overrun; final sequence 0x02, 0x03, 0x04, 0x06.
REQ-039 Assert rst mid-byte during 0x7E, deassert, then send 0x81 -> only 0x181 is read.
